// File: rtl/l74x14_filtered.sv
// rtl/l74x14_filtered.sv - Hex Schmitt-style gate with per-channel digital glitch filter.
// Optional two-flop input synchroniser enabled by macro L74X14_FILTERED_SYNC_EN.
module l74x14_filtered #(
  parameter int CHANNELS      = 6,
  parameter int FILTER_CYCLES = 4,
  parameter int INVERT        = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_a,
  output logic [CHANNELS-1:0] o_y,
  output logic [CHANNELS-1:0] o_chg
);

  localparam int                CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CHANNELS-1:0] INV_MASK = (INVERT != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [CHANNELS-1:0] w_s;

`ifdef L74X14_FILTERED_SYNC_EN
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_a;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_a;
`endif

  logic [CHANNELS-1:0]         r_f;
  logic [CHANNELS-1:0]         w_f_nxt;
  logic [CHANNELS-1:0]         r_chg;
  logic [CHANNELS-1:0]         w_chg_nxt;
  logic [CHANNELS-1:0][CW-1:0] r_cnt;
  logic [CHANNELS-1:0][CW-1:0] w_cnt_nxt;
  logic [CHANNELS-1:0]         w_dis;
  state_t                      w_state [CHANNELS];

  assign w_dis = w_s ^ r_f;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_f   <= '0;
      r_cnt <= '0;
      r_chg <= '0;
    end else begin
      r_f   <= w_f_nxt;
      r_cnt <= w_cnt_nxt;
      r_chg <= w_chg_nxt;
    end
  end

  // The channel state is implied by the counter: any non-zero count is a pending change.
  always_comb begin
    w_f_nxt   = r_f;
    w_cnt_nxt = r_cnt;
    w_chg_nxt = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_state[n] = (r_cnt[n] == '0) ? ST_STABLE : ST_PENDING;
      case (w_state[n])
        ST_STABLE: begin
          if (w_dis[n]) begin
            if (CNT_LAST == '0) begin
              w_f_nxt[n]   = w_s[n];
              w_cnt_nxt[n] = '0;
              w_chg_nxt[n] = 1'b1;
            end else begin
              w_cnt_nxt[n] = CW'(1);
            end
          end
        end
        ST_PENDING: begin
          if (!w_dis[n]) begin
            w_cnt_nxt[n] = '0;
          end else if (r_cnt[n] >= CNT_LAST) begin
            w_f_nxt[n]   = w_s[n];
            w_cnt_nxt[n] = '0;
            w_chg_nxt[n] = 1'b1;
          end else begin
            w_cnt_nxt[n] = r_cnt[n] + CW'(1);
          end
        end
        default: w_cnt_nxt[n] = '0;
      endcase
    end
  end

  assign o_y   = r_f ^ INV_MASK;
  assign o_chg = r_chg;

endmodule

// File: doc/l74x14_filtered.md
L74X14_FILTERED -- requirements
Module: l74x14_filtered

Interface
REQ-001 Parameter CHANNELS, default 6: number of independent gate channels, legal range 1..32.
REQ-002 Parameter FILTER_CYCLES, default 4: consecutive disagreeing samples required before a channel changes state, legal range 1..255.
REQ-003 Parameter INVERT, default 1: 1 selects inverting output (o_y = ~state), 0 selects buffer output (o_y = state).
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_a  input  CHANNELS  raw gate inputs, bit n belongs to channel n.
REQ-007 o_y  output  CHANNELS  filtered gate outputs.
REQ-008 o_chg  output  CHANNELS  one-cycle strobe per channel, high for the cycle after that channel's state changes.

Function
REQ-009 Each channel SHALL hold a 1-bit filtered state f[n] and a disagreement counter cnt[n] of width clog2(FILTER_CYCLES+1); channels SHALL be fully independent.
REQ-010 Sample s[n] SHALL be i_a[n] taken at the rising edge; the optional synchroniser (REQ-021) adds delay.
REQ-011 When s[n] == f[n] at an edge, cnt[n] SHALL clear to 0 and f[n] SHALL hold.
REQ-012 When s[n] != f[n] and cnt[n] < FILTER_CYCLES-1, cnt[n] SHALL increment by 1 and f[n] SHALL hold.
REQ-013 When s[n] != f[n] and cnt[n] == FILTER_CYCLES-1, f[n] SHALL take s[n], cnt[n] SHALL clear to 0, and o_chg[n] SHALL be 1 for exactly the following cycle.
REQ-014 Behaviour per channel is a two-state machine (STABLE: cnt=0, PENDING: cnt>0). STABLE moves to PENDING on a disagreeing sample. PENDING returns to STABLE on an agreeing sample (glitch rejected, no o_chg) or on acceptance (REQ-013).
REQ-015 o_y[n] SHALL be f[n] XOR INVERT, driven directly from the register with no combinational path from i_a.
REQ-016 Latency: an input held at a new level SHALL propagate to o_y after exactly FILTER_CYCLES rising edges, plus 2 edges when the synchroniser is enabled.
REQ-017 A pulse shorter than FILTER_CYCLES samples SHALL produce no change on o_y and no o_chg.
REQ-018 With FILTER_CYCLES=1, any disagreeing sample SHALL be accepted at that edge.
REQ-019 The counter SHALL never exceed FILTER_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While i_rst_n=0, the block SHALL asynchronously force f=0, cnt=0, o_chg=0 and all synchroniser flops to 0, so o_y = {CHANNELS{INVERT}}. Reset asserted mid-PENDING SHALL discard the pending count. After deassertion, the first update SHALL occur at the next rising edge.

Configuration
REQ-021 Macro L74X14_FILTERED_SYNC_EN: when defined, each i_a bit SHALL pass through a two-flop synchroniser before becoming s[n]. When undefined, s[n] = i_a[n] directly and no synchroniser flops SHALL exist. All other behaviour SHALL be identical in both builds.

Verification (CHANNELS=6, FILTER_CYCLES=4, INVERT=1, macro undefined unless stated)
REQ-022 Release reset with i_a=6'h00 -> o_y=6'h3F and o_chg=0; o_y is unchanged after 10 idle cycles.
REQ-023 Drive i_a[0]=1 held -> o_y[0]=0 after the 4th edge; o_chg=6'h01 for exactly one cycle; other bits unchanged.
REQ-024 Drive a 3-cycle pulse on i_a[2], then return to 0 -> o_y stays 6'h3F; o_chg stays 0 throughout.
REQ-025 Set i_a=6'h3F, then assert i_rst_n=0 after 2 edges -> o_y=6'h3F immediately (asynchronously). After release with i_a held, o_y=6'h00 after 4 further edges and o_chg=6'h3F for one cycle.
REQ-026 Build with L74X14_FILTERED_SYNC_EN defined and drive i_a[5]=1 held -> o_y[5] falls after the 6th edge, and not before.
REQ-027 Build with FILTER_CYCLES=1, INVERT=0 and toggle i_a[1] every cycle -> o_y[1] follows i_a[1] one edge later, with o_chg[1] high every cycle.
